// File: rtl/mips_defs.sv
// Shared MIPS encoding constants, class strobe indices and stage action type
// used by the decode stage and its classifier.
package mips_defs;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLEZ  = 6'h06;
    localparam logic [5:0] OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV  = 6'h06;
    localparam logic [5:0] FN_SRAV  = 6'h07;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;

    // Bit positions of the one-hot class strobes inside a class vector.
    localparam int NUM_CLASSES    = 8;
    localparam int CLS_SHIFT      = 0;
    localparam int CLS_SHIFT_VAR  = 1;
    localparam int CLS_JUMP_REL   = 2;
    localparam int CLS_ALU_REG    = 3;
    localparam int CLS_JUMP_ABS   = 4;
    localparam int CLS_BRANCH     = 5;
    localparam int CLS_ALU_INM    = 6;
    localparam int CLS_LOAD_STORE = 7;

    // Value every register-index field takes while the stage holds a bubble.
    localparam logic [4:0] BUBBLE_FIELD = 5'd0;

    // What the stage register does on the coming edge.
    typedef enum logic [1:0] {
        ACT_LOAD   = 2'd0,
        ACT_HOLD   = 2'd1,
        ACT_BUBBLE = 2'd2
    } stage_act_e;

    // Logical immediates are zero-extended; everything else sign-extends.
    function automatic logic imm_zero_ext(input logic [5:0] op);
        return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
    endfunction

endpackage

// File: rtl/instr_classify.sv
// Purely combinational instruction classifier: class strobes, illegal flag,
// destination index, write enable and source-register usage.
module instr_classify
    import mips_defs::*;
#(
    parameter int LINK_REG = 31
) (
    input  logic [5:0]             op,
    input  logic [5:0]             funct,
    input  logic [4:0]             rs_f,
    input  logic [4:0]             rt_f,
    input  logic [4:0]             rd_f,
    output logic [NUM_CLASSES-1:0] class_vec,
    output logic                   illegal,
    output logic [4:0]             dest,
    output logic                   wd,
    output logic                   uses_rs,
    output logic                   uses_rt,
    output logic                   is_load
);

    localparam logic [4:0] LINK_IDX = 5'(LINK_REG);

    logic       has_dest;
    logic [4:0] dest_sel;

    // Decode opcode/funct into a class, pick the destination and note sources.
    always_comb begin
        class_vec = '0;
        illegal   = 1'b0;
        has_dest  = 1'b0;
        dest_sel  = BUBBLE_FIELD;
        uses_rs   = 1'b0;
        uses_rt   = 1'b0;
        is_load   = 1'b0;
        unique case (op)
            OP_RTYPE: begin
                unique case (funct)
                    FN_SLL, FN_SRL, FN_SRA: begin
                        class_vec[CLS_SHIFT] = 1'b1;
                        has_dest = 1'b1;
                        dest_sel = rd_f;
                        uses_rt  = 1'b1;
                    end
                    FN_SLLV, FN_SRLV, FN_SRAV: begin
                        class_vec[CLS_SHIFT_VAR] = 1'b1;
                        has_dest = 1'b1;
                        dest_sel = rd_f;
                        uses_rs  = 1'b1;
                        uses_rt  = 1'b1;
                    end
                    FN_JR: begin
                        class_vec[CLS_JUMP_REL] = 1'b1;
                        uses_rs = 1'b1;
                    end
                    FN_JALR: begin
                        class_vec[CLS_JUMP_REL] = 1'b1;
                        has_dest = 1'b1;
                        dest_sel = rd_f;
                        uses_rs  = 1'b1;
                    end
                    default: begin
                        class_vec[CLS_ALU_REG] = 1'b1;
                        has_dest = 1'b1;
                        dest_sel = rd_f;
                        uses_rs  = 1'b1;
                        uses_rt  = 1'b1;
                    end
                endcase
            end
            OP_J: begin
                class_vec[CLS_JUMP_ABS] = 1'b1;
            end
            OP_JAL: begin
                class_vec[CLS_JUMP_ABS] = 1'b1;
                has_dest = 1'b1;
                dest_sel = LINK_IDX;
            end
            default: begin
                if (op[5:2] == 4'b0001) begin
                    class_vec[CLS_BRANCH] = 1'b1;
                    uses_rs = 1'b1;
                    uses_rt = 1'b1;
                end else if (op[5:3] == 3'b001) begin
                    class_vec[CLS_ALU_INM] = 1'b1;
                    has_dest = 1'b1;
                    dest_sel = rt_f;
                    uses_rs  = 1'b1;
                end else if (op[5:3] == 3'b100) begin
                    class_vec[CLS_LOAD_STORE] = 1'b1;
                    has_dest = 1'b1;
                    dest_sel = rt_f;
                    uses_rs  = 1'b1;
                    is_load  = 1'b1;
                end else if (op[5:3] == 3'b101) begin
                    class_vec[CLS_LOAD_STORE] = 1'b1;
                    uses_rs = 1'b1;
                    uses_rt = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
        endcase
    end

    assign dest = has_dest ? dest_sel : BUBBLE_FIELD;
    assign wd   = has_dest && (dest_sel != 5'd0);

endmodule

// File: rtl/id_decode_stage.sv
// IF/ID pipeline register with instruction decode and one-bubble load-use
// hazard insertion.
module id_decode_stage
    import mips_defs::*;
#(
    parameter int DATA_W    = 32,
    parameter int LINK_REG  = 31,
    parameter int HAZARD_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] if_instr,
    input  logic [DATA_W-1:0] if_pc4,
    input  logic              if_valid,
    input  logic              flush,
    input  logic              ext_hold,
    output logic              stall_out,
    output logic              id_valid,
    output logic              load_store,
    output logic              alu_inm,
    output logic              branch,
    output logic              jump_abs,
    output logic              alu_reg,
    output logic              jump_rel,
    output logic              shift_var,
    output logic              shift,
    output logic              illegal,
    output logic              wd,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [4:0]        dest,
    output logic [4:0]        shamt,
    output logic [DATA_W-1:0] imm_ext,
    output logic [DATA_W-1:0] pc4
);

    logic [5:0]             in_op;
    logic [5:0]             in_funct;
    logic [4:0]             in_rs;
    logic [4:0]             in_rt;
    logic [4:0]             in_rd;
    logic [4:0]             in_shamt;
    logic [15:0]            in_imm16;
    logic [DATA_W-1:0]      in_imm_ext;

    logic [NUM_CLASSES-1:0] dec_class;
    logic                   dec_illegal;
    logic [4:0]             dec_dest;
    logic                   dec_wd;
    logic                   dec_uses_rs;
    logic                   dec_uses_rt;
    logic                   dec_is_load;

    logic [NUM_CLASSES-1:0] class_q;
    logic                   held_is_load;
    logic                   hazard;
    stage_act_e             act;

    assign in_op    = if_instr[31:26];
    assign in_rs    = if_instr[25:21];
    assign in_rt    = if_instr[20:16];
    assign in_rd    = if_instr[15:11];
    assign in_shamt = if_instr[10:6];
    assign in_funct = if_instr[5:0];
    assign in_imm16 = if_instr[15:0];

    assign in_imm_ext = imm_zero_ext(in_op) ? {{(DATA_W-16){1'b0}}, in_imm16}
                                            : {{(DATA_W-16){in_imm16[15]}}, in_imm16};

    instr_classify #(
        .LINK_REG (LINK_REG)
    ) u_classify (
        .op        (in_op),
        .funct     (in_funct),
        .rs_f      (in_rs),
        .rt_f      (in_rt),
        .rd_f      (in_rd),
        .class_vec (dec_class),
        .illegal   (dec_illegal),
        .dest      (dec_dest),
        .wd        (dec_wd),
        .uses_rs   (dec_uses_rs),
        .uses_rt   (dec_uses_rt),
        .is_load   (dec_is_load)
    );

    // Load-use check: the held load's destination is read by the incoming word.
    always_comb begin
        hazard = 1'b0;
        if (HAZARD_EN != 0) begin
            hazard = id_valid && held_is_load && (dest != 5'd0) && if_valid && !flush &&
                     ((dec_uses_rs && (in_rs == dest)) || (dec_uses_rt && (in_rt == dest)));
        end
    end

    assign stall_out = ext_hold || hazard;

    // Edge priority: flush beats hold, hold beats hazard, hazard beats load.
    always_comb begin
        act = ACT_LOAD;
        if (flush) begin
            act = ACT_BUBBLE;
        end else if (ext_hold) begin
            act = ACT_HOLD;
        end else if (hazard || !if_valid) begin
            act = ACT_BUBBLE;
        end
    end

    // Stage register: cleared by reset, then bubble / hold / capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_valid     <= 1'b0;
            class_q      <= '0;
            illegal      <= 1'b0;
            wd           <= 1'b0;
            held_is_load <= 1'b0;
            rs           <= BUBBLE_FIELD;
            rt           <= BUBBLE_FIELD;
            rd           <= BUBBLE_FIELD;
            dest         <= BUBBLE_FIELD;
            shamt        <= BUBBLE_FIELD;
            imm_ext      <= '0;
            pc4          <= '0;
        end else begin
            unique case (act)
                ACT_BUBBLE: begin
                    id_valid     <= 1'b0;
                    class_q      <= '0;
                    illegal      <= 1'b0;
                    wd           <= 1'b0;
                    held_is_load <= 1'b0;
                    rs           <= BUBBLE_FIELD;
                    rt           <= BUBBLE_FIELD;
                    rd           <= BUBBLE_FIELD;
                    dest         <= BUBBLE_FIELD;
                    shamt        <= BUBBLE_FIELD;
                    imm_ext      <= '0;
                    pc4          <= '0;
                end
                ACT_LOAD: begin
                    id_valid     <= 1'b1;
                    class_q      <= dec_class;
                    illegal      <= dec_illegal;
                    wd           <= dec_wd;
                    held_is_load <= dec_is_load;
                    rs           <= in_rs;
                    rt           <= in_rt;
                    rd           <= in_rd;
                    dest         <= dec_dest;
                    shamt        <= in_shamt;
                    imm_ext      <= in_imm_ext;
                    pc4          <= if_pc4;
                end
                default: begin
                end
            endcase
        end
    end

    assign shift      = class_q[CLS_SHIFT];
    assign shift_var  = class_q[CLS_SHIFT_VAR];
    assign jump_rel   = class_q[CLS_JUMP_REL];
    assign alu_reg    = class_q[CLS_ALU_REG];
    assign jump_abs   = class_q[CLS_JUMP_ABS];
    assign branch     = class_q[CLS_BRANCH];
    assign alu_inm    = class_q[CLS_ALU_INM];
    assign load_store = class_q[CLS_LOAD_STORE];

endmodule

// File: tb/tb_id_decode_stage.sv
// Self-checking bench for id_decode_stage: directed vector table, async reset
// mid-hazard sequence and a randomized run against a behavioural model.
module tb_id_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] if_instr;
    logic [31:0] if_pc4;
    logic        if_valid;
    logic        flush;
    logic        ext_hold;
    logic        stall_out;
    logic        id_valid;
    logic        load_store, alu_inm, branch, jump_abs, alu_reg, jump_rel, shift_var, shift;
    logic        illegal;
    logic        wd;
    logic [4:0]  rs, rt, rd, dest, shamt;
    logic [31:0] imm_ext;
    logic [31:0] pc4;

    int n_checks = 0;
    int n_fail   = 0;

    id_decode_stage #(
        .DATA_W    (32),
        .LINK_REG  (31),
        .HAZARD_EN (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .if_instr   (if_instr),
        .if_pc4     (if_pc4),
        .if_valid   (if_valid),
        .flush      (flush),
        .ext_hold   (ext_hold),
        .stall_out  (stall_out),
        .id_valid   (id_valid),
        .load_store (load_store),
        .alu_inm    (alu_inm),
        .branch     (branch),
        .jump_abs   (jump_abs),
        .alu_reg    (alu_reg),
        .jump_rel   (jump_rel),
        .shift_var  (shift_var),
        .shift      (shift),
        .illegal    (illegal),
        .wd         (wd),
        .rs         (rs),
        .rt         (rt),
        .rd         (rd),
        .dest       (dest),
        .shamt      (shamt),
        .imm_ext    (imm_ext),
        .pc4        (pc4)
    );

    always #5 clk = ~clk;

    // Class vector packing: {load_store, alu_inm, branch, jump_abs, alu_reg, jump_rel, shift_var, shift}
    localparam logic [7:0] K_NONE = 8'h00;
    localparam logic [7:0] K_SH   = 8'h01;
    localparam logic [7:0] K_SV   = 8'h02;
    localparam logic [7:0] K_JR   = 8'h04;
    localparam logic [7:0] K_AR   = 8'h08;
    localparam logic [7:0] K_JA   = 8'h10;
    localparam logic [7:0] K_BR   = 8'h20;
    localparam logic [7:0] K_AI   = 8'h40;
    localparam logic [7:0] K_LS   = 8'h80;

    typedef struct {
        logic [31:0] instr;
        logic        valid;
        logic        fl;
        logic        hold;
        logic        exp_stall;
        logic        exp_valid;
        logic [7:0]  exp_cls;
        logic        exp_ill;
        logic        exp_wd;
        logic [4:0]  exp_dest;
        logic [4:0]  exp_rs;
        logic [4:0]  exp_rt;
        logic [31:0] exp_imm;
    } vec_t;

    typedef struct {
        logic        valid;
        logic [7:0]  cls;
        logic        ill;
        logic        wd;
        logic        is_load;
        logic        ur;
        logic        ut;
        logic [4:0]  dest;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [31:0] imm;
        logic [31:0] pc4;
    } mstate_t;

    function automatic logic [7:0] cls_vec();
        return {load_store, alu_inm, branch, jump_abs, alu_reg, jump_rel, shift_var, shift};
    endfunction

    function automatic vec_t mk(input logic [31:0] instr, input logic v, input logic f, input logic h,
                                input logic st, input logic ev, input logic [7:0] cls,
                                input logic ill, input logic w, input logic [4:0] d,
                                input logic [4:0] s, input logic [4:0] t, input logic [31:0] imm);
        vec_t r;
        r.instr = instr; r.valid = v; r.fl = f; r.hold = h;
        r.exp_stall = st; r.exp_valid = ev; r.exp_cls = cls; r.exp_ill = ill;
        r.exp_wd = w; r.exp_dest = d; r.exp_rs = s; r.exp_rt = t; r.exp_imm = imm;
        return r;
    endfunction

    // Behavioural meaning of an instruction word, straight from the ISA class rules.
    function automatic mstate_t model_decode(input logic [31:0] w, input logic [31:0] p4);
        mstate_t m;
        int op;
        int fn;
        logic has_dest;
        op = int'(w[31:26]);
        fn = int'(w[5:0]);
        m = '{default: '0};
        m.valid = 1'b1;
        m.rs = w[25:21]; m.rt = w[20:16]; m.rd = w[15:11]; m.shamt = w[10:6];
        m.pc4 = p4;
        if (op == 12 || op == 13 || op == 14) m.imm = {16'h0000, w[15:0]};
        else m.imm = {{16{w[15]}}, w[15:0]};
        has_dest = 1'b0;
        if (op == 0) begin
            if (fn == 0 || fn == 2 || fn == 3) begin
                m.cls = K_SH; m.ut = 1; has_dest = 1; m.dest = m.rd;
            end else if (fn == 4 || fn == 6 || fn == 7) begin
                m.cls = K_SV; m.ur = 1; m.ut = 1; has_dest = 1; m.dest = m.rd;
            end else if (fn == 8) begin
                m.cls = K_JR; m.ur = 1;
            end else if (fn == 9) begin
                m.cls = K_JR; m.ur = 1; has_dest = 1; m.dest = m.rd;
            end else begin
                m.cls = K_AR; m.ur = 1; m.ut = 1; has_dest = 1; m.dest = m.rd;
            end
        end else if (op == 2) begin
            m.cls = K_JA;
        end else if (op == 3) begin
            m.cls = K_JA; has_dest = 1; m.dest = 5'd31;
        end else if (op >= 4 && op <= 7) begin
            m.cls = K_BR; m.ur = 1; m.ut = 1;
        end else if (op >= 8 && op <= 15) begin
            m.cls = K_AI; m.ur = 1; has_dest = 1; m.dest = m.rt;
        end else if (op >= 32 && op <= 39) begin
            m.cls = K_LS; m.ur = 1; has_dest = 1; m.dest = m.rt; m.is_load = 1;
        end else if (op >= 40 && op <= 47) begin
            m.cls = K_LS; m.ur = 1; m.ut = 1;
        end else begin
            m.ill = 1;
        end
        m.wd = has_dest && (m.dest != 0);
        return m;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [31:0] instr, input logic [31:0] p4, input logic v,
                                  input logic f, input logic h, output logic stall_seen);
        @(negedge clk);
        if_instr = instr; if_pc4 = p4; if_valid = v; flush = f; ext_hold = h;
        #1 stall_seen = stall_out;
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string pfx, input mstate_t e);
        check_output({pfx, "_valid"}, 32'(id_valid), 32'(e.valid));
        check_output({pfx, "_cls"},   32'(cls_vec()), 32'(e.cls));
        check_output({pfx, "_ill"},   32'(illegal),  32'(e.ill));
        check_output({pfx, "_wd"},    32'(wd),       32'(e.wd));
        check_output({pfx, "_dest"},  32'(dest),     32'(e.dest));
        check_output({pfx, "_rs"},    32'(rs),       32'(e.rs));
        check_output({pfx, "_rt"},    32'(rt),       32'(e.rt));
        check_output({pfx, "_rd"},    32'(rd),       32'(e.rd));
        check_output({pfx, "_shamt"}, 32'(shamt),    32'(e.shamt));
        check_output({pfx, "_imm"},   imm_ext,       e.imm);
        check_output({pfx, "_pc4"},   pc4,           e.pc4);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  s, t, d;
        logic [15:0] imm;
        int kind;
        kind = int'($urandom_range(0, 9));
        s = 5'($urandom_range(0, 3));
        t = 5'($urandom_range(0, 3));
        d = 5'($urandom_range(0, 3));
        imm = 16'($urandom);
        op = 6'h00;
        fn = 6'h20;
        case (kind)
            0: fn = 6'($urandom_range(32, 43));
            1: begin logic [1:0] k; k = 2'($urandom_range(0, 2)); fn = (k == 0) ? 6'h00 : (k == 1) ? 6'h02 : 6'h03; end
            2: begin logic [1:0] k; k = 2'($urandom_range(0, 2)); fn = (k == 0) ? 6'h04 : (k == 1) ? 6'h06 : 6'h07; end
            3: fn = 6'($urandom_range(8, 9));
            4: op = 6'($urandom_range(2, 3));
            5: op = 6'($urandom_range(4, 7));
            6: op = 6'($urandom_range(8, 15));
            7: op = 6'($urandom_range(32, 39));
            8: op = 6'($urandom_range(40, 47));
            default: op = 6'($urandom);
        endcase
        if (op == 6'h00) return {op, s, t, d, 5'($urandom), fn};
        return {op, s, t, imm};
    endfunction

    vec_t    vecs[17];
    mstate_t st;
    mstate_t nx;
    mstate_t di;
    logic    stall_seen;

    initial begin
        vecs[0]  = mk(32'h00221820, 1, 0, 0, 0, 1, K_AR,   0, 1, 5'd3,  5'd1, 5'd2, 32'h00001820);
        vecs[1]  = mk(32'h8C250004, 1, 0, 0, 0, 1, K_LS,   0, 1, 5'd5,  5'd1, 5'd5, 32'h00000004);
        vecs[2]  = mk(32'h00A23020, 1, 0, 0, 1, 0, K_NONE, 0, 0, 5'd0,  5'd0, 5'd0, 32'h00000000);
        vecs[3]  = mk(32'h00A23020, 1, 0, 0, 0, 1, K_AR,   0, 1, 5'd6,  5'd5, 5'd2, 32'h00003020);
        vecs[4]  = mk(32'h8C250004, 1, 0, 0, 0, 1, K_LS,   0, 1, 5'd5,  5'd1, 5'd5, 32'h00000004);
        vecs[5]  = mk(32'h00E23020, 1, 0, 0, 0, 1, K_AR,   0, 1, 5'd6,  5'd7, 5'd2, 32'h00003020);
        vecs[6]  = mk(32'h8C200004, 1, 0, 0, 0, 1, K_LS,   0, 0, 5'd0,  5'd1, 5'd0, 32'h00000004);
        vecs[7]  = mk(32'h00023020, 1, 0, 0, 0, 1, K_AR,   0, 1, 5'd6,  5'd0, 5'd2, 32'h00003020);
        vecs[8]  = mk(32'h0C000010, 1, 0, 0, 0, 1, K_JA,   0, 1, 5'd31, 5'd0, 5'd0, 32'h00000010);
        vecs[9]  = mk(32'h0C000010, 1, 1, 0, 0, 0, K_NONE, 0, 0, 5'd0,  5'd0, 5'd0, 32'h00000000);
        vecs[10] = mk(32'h3404FFFF, 1, 0, 0, 0, 1, K_AI,   0, 1, 5'd4,  5'd0, 5'd4, 32'h0000FFFF);
        vecs[11] = mk(32'h00221820, 1, 0, 1, 1, 1, K_AI,   0, 1, 5'd4,  5'd0, 5'd4, 32'h0000FFFF);
        vecs[12] = mk(32'h00221820, 1, 0, 1, 1, 1, K_AI,   0, 1, 5'd4,  5'd0, 5'd4, 32'h0000FFFF);
        vecs[13] = mk(32'h00221820, 1, 0, 1, 1, 1, K_AI,   0, 1, 5'd4,  5'd0, 5'd4, 32'h0000FFFF);
        vecs[14] = mk(32'h00221820, 1, 0, 0, 0, 1, K_AR,   0, 1, 5'd3,  5'd1, 5'd2, 32'h00001820);
        vecs[15] = mk(32'hFC000000, 1, 0, 0, 0, 1, K_NONE, 1, 0, 5'd0,  5'd0, 5'd0, 32'h00000000);
        vecs[16] = mk(32'h00221820, 0, 0, 0, 0, 0, K_NONE, 0, 0, 5'd0,  5'd0, 5'd0, 32'h00000000);

        reset = 1'b1; if_instr = '0; if_pc4 = '0; if_valid = 1'b0; flush = 1'b0; ext_hold = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_valid", 32'(id_valid), 32'd0);
        check_output("rst_cls",   32'(cls_vec()), 32'd0);
        check_output("rst_wd",    32'(wd), 32'd0);
        check_output("rst_imm",   imm_ext, 32'd0);
        check_output("rst_stall", 32'(stall_out), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            apply_stimulus(vecs[i].instr, 32'(i * 4 + 4), vecs[i].valid, vecs[i].fl, vecs[i].hold, stall_seen);
            check_output($sformatf("v%0d_stall", i), 32'(stall_seen), 32'(vecs[i].exp_stall));
            check_output($sformatf("v%0d_valid", i), 32'(id_valid),   32'(vecs[i].exp_valid));
            check_output($sformatf("v%0d_cls", i),   32'(cls_vec()),  32'(vecs[i].exp_cls));
            check_output($sformatf("v%0d_ill", i),   32'(illegal),    32'(vecs[i].exp_ill));
            check_output($sformatf("v%0d_wd", i),    32'(wd),         32'(vecs[i].exp_wd));
            check_output($sformatf("v%0d_dest", i),  32'(dest),       32'(vecs[i].exp_dest));
            check_output($sformatf("v%0d_rs", i),    32'(rs),         32'(vecs[i].exp_rs));
            check_output($sformatf("v%0d_rt", i),    32'(rt),         32'(vecs[i].exp_rt));
            check_output($sformatf("v%0d_imm", i),   imm_ext,         vecs[i].exp_imm);
        end

        // Reset asserted mid-hazard clears the stage without a clock edge.
        apply_stimulus(32'h8C250004, 32'h100, 1, 0, 0, stall_seen);
        @(negedge clk);
        if_instr = 32'h00A23020; if_pc4 = 32'h104; if_valid = 1'b1;
        #1;
        check_output("mid_stall", 32'(stall_out), 32'd1);
        reset = 1'b1;
        #1;
        check_output("arst_valid", 32'(id_valid), 32'd0);
        check_output("arst_cls",   32'(cls_vec()), 32'd0);
        check_output("arst_dest",  32'(dest), 32'd0);
        check_output("arst_pc4",   pc4, 32'd0);
        check_output("arst_stall", 32'(stall_out), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_output("post_stall", 32'(stall_out), 32'd0);
        @(posedge clk);
        #1;
        check_output("post_valid", 32'(id_valid), 32'd1);
        check_output("post_cls",   32'(cls_vec()), 32'(K_AR));
        check_output("post_dest",  32'(dest), 32'd6);
        check_output("post_pc4",   pc4, 32'h104);

        // Randomized run against the behavioural model; fetch re-presents on stall.
        st = model_decode(32'h00A23020, 32'h104);
        begin
            logic [31:0] w;
            logic [31:0] p;
            logic        v, f, h, haz, exp_stall;
            w = rand_instr();
            p = 32'h200;
            for (int c = 0; c < 400; c++) begin
                v = ($urandom_range(0, 99) < 85);
                f = ($urandom_range(0, 99) < 8);
                h = ($urandom_range(0, 99) < 12);
                di = model_decode(w, p);
                haz = st.valid && st.is_load && (st.dest != 0) && v && !f &&
                      ((di.ur && di.rs == st.dest) || (di.ut && di.rt == st.dest));
                exp_stall = h || haz;
                if (f) nx = '{default: '0};
                else if (h) nx = st;
                else if (haz || !v) nx = '{default: '0};
                else nx = di;
                apply_stimulus(w, p, v, f, h, stall_seen);
                check_output($sformatf("r%0d_stall", c), 32'(stall_seen), 32'(exp_stall));
                check_model($sformatf("r%0d", c), nx);
                st = nx;
                if (!exp_stall || f) begin
                    w = rand_instr();
                    p = p + 32'd4;
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
